// File: rtl/mdu_iterative.sv
// mdu_iterative -- iterative RV32M/RV64M multiply/divide unit for the EX stage.
//
// Takes M-extension ops (funct3-encoded) one at a time. It does one radix-2 step
// per cycle: multiply uses shift-add and divide uses restoring division. It returns
// an XLEN result together with the writeback tag that came in with the op.
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   defined   : multiply with a zero operand, and DIVU/REMU with op_a < op_b,
//               complete in one cycle (IDLE -> DONE).
//   undefined : those ops run the full iteration. The results are the same.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               abort in-flight op; any state returns to IDLE next edge
//   in_valid/in_ready   op request / unit idle and able to accept
//   funct3              000 MUL 001 MULH 010 MULHSU 011 MULHU
//                       100 DIV 101 DIVU 110 REM  111 REMU
//   op_a, op_b          rs1 / rs2 values
//   tag_in              destination tag, returned unchanged on tag_out
//   out_valid/out_ready result valid / consumer accepts
//   result, tag_out     result and its tag (held stable while out_valid)
//   busy                unit is not IDLE
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Once valid is raised, the payload holds until that transfer. flush
// overrides both channels. An op presented while flush is high is not accepted.
// A result showing when flush rises is dropped (out_valid is forced low).
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  // Latched operation context.
  logic [2:0]        op_q;
  logic              neg_q;   // negate the final value (product/quotient or remainder)
  logic [XLEN-1:0]   mcand;   // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] acc;     // mul: {partial product, multiplier}; div: {rem, dividend/quotient}
  logic [CW-1:0]     cnt;

  // ---------------------------------------------------------------------------
  // Request decode: operand signedness, magnitudes, special cases
  // ---------------------------------------------------------------------------
  logic            a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
               (funct3 == F_DIV)  || (funct3 == F_REM);
    b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  end

  assign sign_a = a_signed & op_a[XLEN-1];
  assign sign_b = b_signed & op_b[XLEN-1];
  // The magnitude of MIN_INT is MIN_INT itself, read as unsigned. That is exactly 2^(XLEN-1).
  assign abs_a  = sign_a ? ({XLEN{1'b0}} - op_a) : op_a;
  assign abs_b  = sign_b ? ({XLEN{1'b0}} - op_b) : op_b;
  // The remainder takes the dividend's sign. Products and quotients take the XOR of both signs.
  assign neg_in = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);

  logic            div_zero, div_ovf, early_mul, early_divu, special;
  logic [XLEN-1:0] special_res;

  assign div_zero = funct3[2] && (op_b == {XLEN{1'b0}});
  assign div_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                    (op_a == MIN_INT) && (op_b == {XLEN{1'b1}});

`ifdef MDU_EARLY_OUT_EN
  assign early_mul  = !funct3[2] && ((op_a == {XLEN{1'b0}}) || (op_b == {XLEN{1'b0}}));
  assign early_divu = ((funct3 == F_DIVU) || (funct3 == F_REMU)) && (op_a < op_b);
`else
  assign early_mul  = 1'b0;
  assign early_divu = 1'b0;
`endif

  assign special = div_zero || div_ovf || early_mul || early_divu;

  // The early-out multiply case leaves the value at the zero default.
  always_comb begin
    special_res = {XLEN{1'b0}};
    if (div_zero)
      special_res = funct3[1] ? op_a : {XLEN{1'b1}};
    else if (div_ovf)
      special_res = funct3[1] ? {XLEN{1'b0}} : MIN_INT;
    else if (early_divu)
      special_res = funct3[1] ? op_a : {XLEN{1'b0}};
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] step_next;

  assign acc_hi = acc[2*XLEN-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    // The partial remainder, shifted with the next dividend bit brought in, is XLEN+1 bits wide.
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand};
    step_next = {2*XLEN{1'b0}};
    if (op_q[2]) begin
      if (!div_trial[XLEN])
        step_next = {div_trial[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
      else
        step_next = {div_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
    end else begin
      // Shift right. The carry-out of the add becomes the new top bit.
      step_next = {mul_sum, acc_lo[XLEN-1:1]};
    end
  end

  // The sign fix-up is applied to the value the final step produces.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  always_comb begin
    prod_fix = neg_q ? ({2*XLEN{1'b0}} - step_next) : step_next;
    quo_fix  = neg_q ? ({XLEN{1'b0}} - step_next[XLEN-1:0]) : step_next[XLEN-1:0];
    rem_fix  = neg_q ? ({XLEN{1'b0}} - step_next[2*XLEN-1:XLEN])
                     : step_next[2*XLEN-1:XLEN];
    calc_res = {XLEN{1'b0}};
    if (op_q[2])
      calc_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00)
      calc_res = prod_fix[XLEN-1:0];
    else
      calc_res = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic accept, last_step;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == S_DONE) && !flush;
  assign busy      = (state != S_IDLE);
  assign last_step = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = special ? S_DONE : S_CALC;
      S_CALC:  if (last_step) state_n = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 3'b000;
      neg_q   <= 1'b0;
      mcand   <= {XLEN{1'b0}};
      acc     <= {2*XLEN{1'b0}};
      cnt     <= {CW{1'b0}};
      result  <= {XLEN{1'b0}};
      tag_out <= {TAG_W{1'b0}};
    end else if (accept) begin
      op_q    <= funct3;
      neg_q   <= neg_in;
      tag_out <= tag_in;
      cnt     <= {CW{1'b0}};
      if (funct3[2]) begin
        mcand <= abs_b;
        acc   <= {{XLEN{1'b0}}, abs_a};
      end else begin
        mcand <= abs_a;
        acc   <= {{XLEN{1'b0}}, abs_b};
      end
      if (special) result <= special_res;
    end else if ((state == S_CALC) && !flush) begin
      acc <= step_next;
      cnt <= cnt + 1'b1;
      if (last_step) result <= calc_res;
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative -- testbench for mdu_iterative (XLEN=32, TAG_W=5).
// A driver issues ops and pushes the expected {tag, result} and latency into queues.
// A monitor running on the falling edge pops those entries and compares them to what
// the unit presents. It also checks that result and tag hold steady, and that
// in_ready stays low while a result is waiting.
`timescale 1ns/1ps
module tb_mdu_iterative;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int W     = XLEN + TAG_W;
  localparam logic [XLEN-1:0] MIN_INT = 32'h8000_0000;
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [2:0]       funct3 = 3'd0;
  logic [XLEN-1:0]  op_a = '0, op_b = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             in_ready, out_valid, busy;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_iterative #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [127:0] sa, sb, p, q, r;
    bit a_sgn, b_sgn;
    a_sgn = (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
    b_sgn = (f == MULH) || (f == DIV) || (f == REM);
    sa = a_sgn ? 128'($signed(a)) : 128'(a);
    sb = b_sgn ? 128'($signed(b)) : 128'(b);
    if (!f[2]) begin
      p = sa * sb;
      return (f == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end
    if (b == '0) return f[1] ? a : '1;
    q = sa / sb;   // truncates toward zero; remainder takes the dividend's sign
    r = sa % sb;
    return f[1] ? r[XLEN-1:0] : q[XLEN-1:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    int lat;
    lat = XLEN + 1;
    if (f[2] && b == '0) lat = 1;
    if ((f == DIV || f == REM) && a == MIN_INT && b == '1) lat = 1;
`ifdef MDU_EARLY_OUT_EN
    if (!f[2] && (a == '0 || b == '0)) lat = 1;
    if ((f == DIVU || f == REMU) && a < b) lat = 1;
`endif
    return lat;
  endfunction

  // ---------------- monitor ----------------
  logic             ov_prev = 1'b0;
  logic [XLEN-1:0]  held_res;
  logic [TAG_W-1:0] held_tag;
  int               m_lat, m_acc;
  logic [W-1:0]     m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_in_done", in_ready, 0);
        if (!ov_prev) begin
          if (lat_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_out_valid: result 0x%0h presented, required no output", result);
          end else begin
            m_lat = lat_q.pop_front();
            m_acc = acc_q.pop_front();
            check("latency", cyc - m_acc + 1, m_lat);
          end
        end else begin
          check("hold_result", result, held_res);
          check("hold_tag", tag_out, held_tag);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_result: 0x%0h taken, required none", result);
          end else begin
            m_exp = exp_q.pop_front();
            check("result", result, m_exp[XLEN-1:0]);
            check("tag", tag_out, m_exp[W-1:XLEN]);
          end
        end
      end
      ov_prev  <= out_valid && !out_ready;
      held_res <= result;
      held_tag <= tag_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] t, input bit expect_out);
    int g;
    g = 0;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; tag_in = t; in_valid = 1'b1;
    while (!in_ready && g < 500) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", g);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (expect_out) begin
      exp_q.push_back({t, ref_model(f, a, b)});
      lat_q.push_back(exp_lat(f, a, b));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_done(input bit rnd_ready);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 500) begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      g++;
    end
    out_ready = 1'b1;
    if (g >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); lat_q.delete(); acc_q.delete();
    end
  endtask

  task automatic wait_valid();
    int g;
    g = 0;
    while (!out_valid && g < 200) begin @(negedge clk); g++; end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: out_valid 0 after %0d cycles, required 1", g);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_out_valid"}, out_valid, 0);
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return MIN_INT;
      2:       return '1;
      3:       return XLEN'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  typedef struct packed { logic [2:0] f; logic [XLEN-1:0] a; logic [XLEN-1:0] b; } op_t;
  op_t dir_ops[14];

  initial begin
    dir_ops[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD};
    dir_ops[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000};
    dir_ops[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    dir_ops[3]  = '{DIV,    32'hFFFF_FFF9,  32'd2};
    dir_ops[4]  = '{REM,    32'hFFFF_FFF9,  32'd2};
    dir_ops[5]  = '{DIVU,   32'd100,        32'd7};
    dir_ops[6]  = '{REMU,   32'd100,        32'd7};
    dir_ops[7]  = '{DIV,    32'd5,          32'd0};
    dir_ops[8]  = '{REM,    32'h8000_0000,  32'hFFFF_FFFF};
    dir_ops[9]  = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF};
    dir_ops[10] = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    dir_ops[11] = '{REMU,   32'd5,          32'd0};
    dir_ops[12] = '{MUL,    32'd0,          32'h1234_5678};
    dir_ops[13] = '{DIVU,   32'd3,          32'd9};

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_result", result, 0);
    check("reset_tag", tag_out, 0);
    rst_n = 1'b1;

    // Directed ops.
    for (int i = 0; i < 14; i++) begin
      issue(dir_ops[i].f, dir_ops[i].a, dir_ops[i].b, TAG_W'(i + 1), 1'b1);
      wait_done(1'b0);
    end

    // Consumer stall: the result must hold for 10 cycles with in_ready low.
    out_ready = 1'b0;
    issue(DIVU, 32'd100, 32'd7, 5'd21, 1'b1);
    wait_valid();
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(1'b0);

    // Flush during CALC cycle 12: nothing may come out, and a new op then works.
    issue(MUL, 32'h1234_5677, 32'h0BAD_F00D, 5'd9, 1'b0);
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check_idle("flush_calc");
    repeat (40) @(negedge clk);
    issue(MULH, 32'hDEAD_BEEF, 32'h7654_3211, 5'd10, 1'b1);
    wait_done(1'b0);

    // Flush in the same cycle as a request: nothing is accepted.
    @(negedge clk);
    funct3 = DIVU; op_a = 32'd50; op_b = 32'd3; tag_in = 5'd11;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_idle("flush_accept");

    // Flush while a result waits in DONE: the result is dropped.
    out_ready = 1'b0;
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 1'b1);
    wait_valid();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check_idle("flush_done");
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (5) @(negedge clk);
    out_ready = 1'b1;

    // Reset in the middle of an op: reset values come back at once.
    issue(DIVU, 32'hF000_0000, 32'd3, 5'd13, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_idle("midreset");
    check("midreset_result", result, 0);
    check("midreset_tag", tag_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Random ops, with out_ready toggled at random for part of them.
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand(),
            TAG_W'($urandom_range(0, 31)), 1'b1);
      wait_done(i >= 40);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
